// File: rtl/uart_rx_frame_fifo_if.sv
// Receive-side bundle between a UART deserialiser/consumer and uart_rx_frame_fifo.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface uart_rx_frame_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int FRAME_W   = 11,
    parameter int CNT_W     = 4
);
    logic [FRAME_W-1:0]   data_parll;
    logic                 recieved_flag;
    logic                 rd_en;
    logic                 err_clr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_perr;
    logic                 rd_ferr;
    logic                 empty;
    logic                 full;
    logic [CNT_W-1:0]     count;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport slave (
        input  data_parll, recieved_flag, rd_en, err_clr,
        output rd_data, rd_perr, rd_ferr, empty, full, count,
               parity_err, frame_err, overrun_err
    );

    modport master (
        output data_parll, recieved_flag, rd_en, err_clr,
        input  rd_data, rd_perr, rd_ferr, empty, full, count,
               parity_err, frame_err, overrun_err
    );
endinterface

// File: rtl/uart_rx_frame_fifo.sv
// UART frame checker + FIFO: capture, then check/write (entry visible 2 edges after recieved_flag); writes into a full FIFO are dropped with overrun_err.
// Define UART_RX_ERR_DROP_EN to discard frames with parity/framing errors instead of storing them tagged.
module uart_rx_frame_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  baud_clk,
    input  logic                  reset_n,
    uart_rx_frame_fifo_if.slave   bus
);
    localparam int FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef struct packed {
        logic                 ferr;
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    logic [FRAME_W-1:0]   cap_q;
    logic                 cap_vld_q;
    entry_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 rd_perr_q, rd_ferr_q;
    logic                 perr_flag_q, perr_flag_d;
    logic                 ferr_flag_q, ferr_flag_d;
    logic                 ovr_flag_q, ovr_flag_d;

    logic [DATA_BITS-1:0] cap_data;
    logic [STOP_BITS-1:0] cap_stop;
    logic                 perr, ferr;
    logic                 wr_req, is_full, pop, push, ovr;
    entry_t               wr_entry;

    assign cap_data = cap_q[DATA_BITS:1];
    assign cap_stop = cap_q[FRAME_W-1 -: STOP_BITS];
    assign ferr     = cap_q[0] | ~(&cap_stop);

    generate
        if (PARITY_EN != 0) begin : g_par
            assign perr = ((^cap_data) ^ cap_q[DATA_BITS+1]) != (PARITY_ODD != 0);
        end else begin : g_nopar
            assign perr = 1'b0;
        end
    endgenerate

`ifdef UART_RX_ERR_DROP_EN
    assign wr_req = cap_vld_q & ~perr & ~ferr;
`else
    assign wr_req = cap_vld_q;
`endif

    // Only clean frames reach the FIFO when dropping is enabled, so stored tags are then always 0.
    assign wr_entry = '{ferr: ferr, perr: perr, data: cap_data};
    assign is_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop      = bus.rd_en && (count_q != '0);
    assign push     = wr_req && (!is_full || pop);
    assign ovr      = wr_req && is_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A detection in the same cycle as err_clr leaves the flag set.
        perr_flag_d = bus.err_clr ? 1'b0 : perr_flag_q;
        ferr_flag_d = bus.err_clr ? 1'b0 : ferr_flag_q;
        ovr_flag_d  = bus.err_clr ? 1'b0 : ovr_flag_q;
        if (cap_vld_q && perr) perr_flag_d = 1'b1;
        if (cap_vld_q && ferr) ferr_flag_d = 1'b1;
        if (ovr)               ovr_flag_d  = 1'b1;
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q       <= '0;
            cap_vld_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_perr_q   <= 1'b0;
            rd_ferr_q   <= 1'b0;
            perr_flag_q <= 1'b0;
            ferr_flag_q <= 1'b0;
            ovr_flag_q  <= 1'b0;
        end else begin
            cap_vld_q <= bus.recieved_flag;
            if (bus.recieved_flag) cap_q <= bus.data_parll;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            perr_flag_q <= perr_flag_d;
            ferr_flag_q <= ferr_flag_d;
            ovr_flag_q  <= ovr_flag_d;
            if (pop) begin
                rd_data_q <= mem_q[rd_ptr_q].data;
                rd_perr_q <= mem_q[rd_ptr_q].perr;
                rd_ferr_q <= mem_q[rd_ptr_q].ferr;
            end
        end
    end

    // Storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge baud_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_perr     = rd_perr_q;
    assign bus.rd_ferr     = rd_ferr_q;
    assign bus.count       = count_q;
    assign bus.empty       = (count_q == '0);
    assign bus.full        = is_full;
    assign bus.parity_err  = perr_flag_q;
    assign bus.frame_err   = ferr_flag_q;
    assign bus.overrun_err = ovr_flag_q;
endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Bench for uart_rx_frame_fifo (default parameters): queue-based reference model checked every cycle plus directed literal checks.
module tb_uart_rx_frame_fifo;
    localparam int DB    = 8;
    localparam int FW    = 11;
    localparam int CW    = 4;
    localparam int DEPTH = 8;
    localparam int PODD  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_fifo_if #(.DATA_BITS(DB), .FRAME_W(FW), .CNT_W(CW)) bus ();

    uart_rx_frame_fifo dut (
        .baud_clk (clk),
        .reset_n  (rst_n),
        .bus      (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {ferr, perr, data} plus a one-deep capture stage.
    logic [9:0]    mq [$];
    logic [DB-1:0] m_rd_data = '0;
    logic          m_rd_perr = 1'b0, m_rd_ferr = 1'b0;
    logic          m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    logic          m_pend = 1'b0;
    logic [FW-1:0] m_pend_frame = '0;

    always @(posedge clk or negedge rst_n) begin : model
        logic       pop_ok, pe, fe, keep;
        int         ones;
        logic [9:0] e;
        if (!rst_n) begin
            mq.delete();
            m_rd_data = '0; m_rd_perr = 1'b0; m_rd_ferr = 1'b0;
            m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            m_pend = 1'b0; m_pend_frame = '0;
        end else begin
            pop_ok = bus.rd_en && (mq.size() > 0);
            if (bus.err_clr) begin
                m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            end
            keep = 1'b0;
            pe = 1'b0;
            fe = 1'b0;
            if (m_pend) begin
                ones = 0;
                for (int i = 1; i <= DB; i++) ones += int'(m_pend_frame[i]);
                pe = ((ones + int'(m_pend_frame[DB+1])) % 2) != PODD;
                fe = (m_pend_frame[0] != 1'b0) || (m_pend_frame[FW-1] != 1'b1);
                if (pe) m_perr = 1'b1;
                if (fe) m_ferr = 1'b1;
                keep = 1'b1;
`ifdef UART_RX_ERR_DROP_EN
                keep = !(pe || fe);
`endif
            end
            if (pop_ok) begin
                e = mq.pop_front();
                m_rd_ferr = e[9];
                m_rd_perr = e[8];
                m_rd_data = e[7:0];
            end
            if (keep) begin
                if (mq.size() < DEPTH) mq.push_back({fe, pe, m_pend_frame[DB:1]});
                else m_ovr = 1'b1;
            end
            m_pend       = bus.recieved_flag;
            m_pend_frame = bus.data_parll;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_count",   32'(bus.count),   32'(mq.size()));
            chk("m_empty",   32'(bus.empty),   32'(mq.size() == 0));
            chk("m_full",    32'(bus.full),    32'(mq.size() == DEPTH));
            chk("m_rd_data", 32'(bus.rd_data), 32'(m_rd_data));
            chk("m_rd_perr", 32'(bus.rd_perr), 32'(m_rd_perr));
            chk("m_rd_ferr", 32'(bus.rd_ferr), 32'(m_rd_ferr));
            chk("m_perr",    32'(bus.parity_err),  32'(m_perr));
            chk("m_ferr",    32'(bus.frame_err),   32'(m_ferr));
            chk("m_ovr",     32'(bus.overrun_err), 32'(m_ovr));
        end
    end

    function automatic logic [FW-1:0] mk(input logic [DB-1:0] d, input logic bad_par, input logic stop);
        logic p;
        p = (^d) ^ (PODD != 0) ^ bad_par;
        return {stop, p, d, 1'b0};
    endfunction

    // Inputs change 1 time unit after each rising edge and are held for one full cycle.
    task automatic drive(input logic flag, input logic [FW-1:0] f, input logic rd, input logic clr);
        bus.recieved_flag = flag;
        bus.data_parll    = f;
        bus.rd_en         = rd;
        bus.err_clr       = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.recieved_flag = 1'b0;
        bus.data_parll    = '0;
        bus.rd_en         = 1'b0;
        bus.err_clr       = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full),  0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // Clean 0xA5 frame, even parity bit 0
        drive(1'b1, mk(8'hA5, 1'b0, 1'b1), 1'b0, 1'b0);
        chk("a5_cnt_after_capture", 32'(bus.count), 0);
        idle();
        chk("a5_cnt", 32'(bus.count), 1);
        chk("a5_empty", 32'(bus.empty), 0);
        pop();
        chk("a5_data", 32'(bus.rd_data), 32'h A5);
        chk("a5_perr", 32'(bus.rd_perr), 0);
        chk("a5_ferr", 32'(bus.rd_ferr), 0);
        chk("a5_empty_after_pop", 32'(bus.empty), 1);

        // 0x01 with parity bit 0 under even parity
        drive(1'b1, mk(8'h01, 1'b1, 1'b1), 1'b0, 1'b0);
        idle();
        chk("p01_parity_err", 32'(bus.parity_err), 1);
`ifdef UART_RX_ERR_DROP_EN
        chk("p01_dropped_cnt", 32'(bus.count), 0);
        idle();
`else
        chk("p01_cnt", 32'(bus.count), 1);
        pop();
        chk("p01_rd_perr", 32'(bus.rd_perr), 1);
        chk("p01_rd_data", 32'(bus.rd_data), 32'h01);
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("p01_cleared", 32'(bus.parity_err), 0);

        // 0x3C with stop bit 0
        drive(1'b1, mk(8'h3C, 1'b0, 1'b0), 1'b0, 1'b0);
        idle();
        chk("f3c_frame_err", 32'(bus.frame_err), 1);
        chk("f3c_parity_ok", 32'(bus.parity_err), 0);
`ifndef UART_RX_ERR_DROP_EN
        pop();
        chk("f3c_rd_ferr", 32'(bus.rd_ferr), 1);
        chk("f3c_rd_data", 32'(bus.rd_data), 32'h3C);
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("f3c_cleared", 32'(bus.frame_err), 0);

        // Framing error detected on the same edge as err_clr: set wins
        drive(1'b1, mk(8'h3C, 1'b0, 1'b0), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("setwins_frame_err", 32'(bus.frame_err), 1);
        drive(1'b0, '0, 1'b1, 1'b1);
        chk("setwins_then_clr", 32'(bus.frame_err), 0);
        idle();

        // Nine back-to-back frames into depth 8
        for (int i = 0; i < 9; i++) drive(1'b1, mk(8'(i), 1'b0, 1'b1), 1'b0, 1'b0);
        idle();
        chk("nine_full", 32'(bus.full), 1);
        chk("nine_cnt", 32'(bus.count), 8);
        chk("nine_ovr", 32'(bus.overrun_err), 1);
        for (int i = 0; i < 8; i++) begin
            pop();
            chk("nine_pop_data", 32'(bus.rd_data), 32'(i));
        end
        chk("nine_empty", 32'(bus.empty), 1);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("nine_ovr_cleared", 32'(bus.overrun_err), 0);

        // Full FIFO: pop and write 0x55 on the same edge
        for (int i = 0; i < 8; i++) drive(1'b1, mk(8'(8'h10 + i), 1'b0, 1'b1), 1'b0, 1'b0);
        drive(1'b1, mk(8'h55, 1'b0, 1'b1), 1'b0, 1'b0);
        chk("pw_full_before", 32'(bus.full), 1);
        pop();
        chk("pw_cnt", 32'(bus.count), 8);
        chk("pw_no_ovr", 32'(bus.overrun_err), 0);
        chk("pw_first", 32'(bus.rd_data), 32'h10);
        for (int i = 1; i < 8; i++) begin
            pop();
            chk("pw_pop_data", 32'(bus.rd_data), 32'(8'h10 + i));
        end
        pop();
        chk("pw_last_55", 32'(bus.rd_data), 32'h55);
        chk("pw_empty", 32'(bus.empty), 1);

        // Write and pop on the same edge while empty: pop ignored
        drive(1'b1, mk(8'h66, 1'b0, 1'b1), 1'b0, 1'b0);
        pop();
        chk("we_cnt", 32'(bus.count), 1);
        chk("we_rd_hold", 32'(bus.rd_data), 32'h55);
        pop();
        chk("we_data", 32'(bus.rd_data), 32'h66);

        // Pop while empty leaves everything unchanged
        pop();
        chk("re_hold_data", 32'(bus.rd_data), 32'h66);
        chk("re_cnt", 32'(bus.count), 0);
        chk("re_no_ovr", 32'(bus.overrun_err), 0);
        idle();

        // Reset with three entries held and a frame in capture
        drive(1'b1, mk(8'h70, 1'b1, 1'b1), 1'b0, 1'b0);
        drive(1'b1, mk(8'h71, 1'b0, 1'b1), 1'b0, 1'b0);
        drive(1'b1, mk(8'h72, 1'b0, 1'b1), 1'b0, 1'b0);
        drive(1'b1, mk(8'h73, 1'b0, 1'b1), 1'b0, 1'b0);
        chk("rs_cnt3", 32'(bus.count), 3);
        chk("rs_perr_set", 32'(bus.parity_err), 1);
        bus.recieved_flag = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rs_empty", 32'(bus.empty), 1);
        chk("rs_cnt", 32'(bus.count), 0);
        chk("rs_rd_data", 32'(bus.rd_data), 0);
        chk("rs_flags", 32'({bus.parity_err, bus.frame_err, bus.overrun_err}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        idle();
        chk("rs_capture_discarded", 32'(bus.count), 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
